uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
Receive-side controller for the serial receiver. It captures each byte the receiver reports and pushes it into a 16-entry FIFO. It exposes a strobe/valid read port and status to the CPU bus, and raises an interrupt on fill threshold, idle timeout or overrun. It sits between the receiver's rx_data/rx_received outputs and the CPU I/O decode.

Parameters:
DEPTH, 16, FIFO entries; must be a power of two.
AW, 4, log2(DEPTH); pointer width.
IRQ_THRESH, 8, fill level (1..DEPTH) at which the threshold interrupt asserts.
TIMEOUT_CYCLES, 17360, idle cycles with a non-empty FIFO before the timeout interrupt (4 character times at 115200 baud, 50 MHz). Counter width is 15 bits.

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  synchronous reset, active-low (0 = reset)
rx_data  in  8  receiver byte; valid only while rx_received=1, high-Z otherwise
rx_received  in  1  receiver byte-done flag; high for >=1 cycle per byte
rx_en  in  1  1 = accept bytes into the FIFO
rd_strobe  in  1  CPU read request, one cycle
rd_data  out  8  popped byte, registered
rd_valid  out  1  one-cycle pulse; rd_data is valid
count  out  AW+1  current fill level, 0..DEPTH
empty  out  1  count==0
full  out  1  count==DEPTH
overrun  out  1  sticky: a byte was dropped because the FIFO was full
ovr_clr  in  1  clears overrun
irq_en  in  1  interrupt enable
irq  out  1  registered interrupt request

Behaviour:
- Reset (rst=0 at posedge): wr_ptr=rd_ptr=0, count=0, empty=1, full=0, overrun=0, rd_data=8'h00, rd_valid=0, irq=0, timeout counter=0, rx_recv_d=0. Reset mid-transfer discards all FIFO contents.
- Edge detect: rx_recv_d registers rx_received. push = rx_received & ~rx_recv_d & rx_en. A level held high for several cycles yields exactly one push.
- rx_data is sampled only in the push cycle and written at that posedge. It is never used while rx_received=0, because the bus is high-Z then.
- rx_en=0: no pushes and no overrun. Contents are retained and reads still operate.
- Push while full with no pop in the same cycle: byte dropped, overrun<=1. overrun stays set until an ovr_clr cycle. If ovr_clr and a new overrun occur together, set wins.
- Pop: rd_strobe & ~empty. rd_data<=mem[rd_ptr] and rd_valid<=1 on the next posedge (latency 1). rd_ptr increments.
- rd_strobe while empty: ignored. rd_valid=0 and rd_data holds its previous value.
- Simultaneous push and pop:
  - full: both execute, no overrun, count unchanged.
  - empty: pop ignored, push executes, count becomes 1.
  - otherwise: both execute, count unchanged.
- Pointers wrap modulo DEPTH. count, empty and full are registered and consistent in the same cycle.
- Timeout counter:
  - cleared to 0 on any push, any pop, or while empty;
  - otherwise increments by 1 per cycle, saturating at TIMEOUT_CYCLES;
  - tmo_hit = (counter == TIMEOUT_CYCLES).
- irq <= irq_en & ((count_next >= IRQ_THRESH) | tmo_hit | overrun_next). This is registered, so it asserts one cycle after the causing state update. It deasserts when the causes clear or when irq_en=0.
- Controller states: IDLE (empty), FILLING (non-empty, counter running), TIMED_OUT (non-empty, counter saturated). Transitions:
  - IDLE->FILLING on push;
  - FILLING->TIMED_OUT when the counter reaches TIMEOUT_CYCLES;
  - TIMED_OUT->FILLING on push, or on a pop that leaves the FIFO non-empty;
  - any state->IDLE when count becomes 0.

Decomposition:
- Shared package uart_pkg:
  - UART_CLK_DIV=434
  - UART_BITS_PER_CHAR=10
  - UART_CHAR_CYCLES=4340
  - default RX_FIFO_DEPTH=16
  - controller state encoding (IDLE=2'd0, FILLING=2'd1, TIMED_OUT=2'd2)
- Sub-module uart_sync_fifo (DEPTH/AW/8-bit width parameters) holds the storage, pointers, count, empty and full. The push/pop qualification rules above are applied in uart_rx_ctrl.

Test Plan:
- Reset, then push 0x41,0x42,0x43 (rx_received held high 1 cycle each, >=10 cycles apart), then 3 rd_strobe -> rd_data 0x41,0x42,0x43, each with a 1-cycle rd_valid one cycle after its strobe; count 3->0; empty=1.
- rx_received held high 5 cycles with rx_data=0x55 -> exactly one entry, count=1.
- Push 17 bytes 0x00..0x10 with no reads -> full=1 at 16, overrun=1 after the 17th, irq=1 with irq_en=1. Draining yields 0x00..0x0F (0x10 lost). ovr_clr -> overrun=0.
- With full=1, push 0xAA in the same cycle as rd_strobe -> overrun stays 0, count stays 16, 0xAA is the last byte read. With empty=1, push 0xBB plus rd_strobe -> rd_valid=0, count=1.
- Push 1 byte with irq_en=1 and IRQ_THRESH=8, then idle -> irq=0 until 17360 idle cycles, irq=1 on the following cycle. A pop clears the counter and irq.
- Pull rst=0 mid-stream with count=5 -> next cycle count=0, empty=1, irq=0, overrun=0, rd_valid=0; a push with rx_en=0 leaves count=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants and the receive controller state encoding.
// No ports; imported by the receive-side modules.
package uart_pkg;

    localparam int UART_CLK_DIV       = 434;   // 50 MHz / 115200 baud
    localparam int UART_BITS_PER_CHAR = 10;    // start + 8 data + stop
    localparam int UART_CHAR_CYCLES   = 4340;  // clocks per character
    localparam int RX_FIFO_DEPTH      = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,  // FIFO empty
        ST_FILLING   = 2'd1,  // non-empty, idle counter running
        ST_TIMED_OUT = 2'd2   // non-empty, idle counter saturated
    } rx_state_t;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Receiver-to-CPU bus for the receive controller.
// master: receiver/CPU side (drives bytes, read strobe, controls).
// slave : controller side (drives read data, status and irq).
interface uart_rx_ctrl_if #(
    parameter int AW = 4
);
    logic [7:0]  rx_data;
    logic        rx_received;
    logic        rx_en;
    logic        rd_strobe;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic [AW:0] count;
    logic        empty;
    logic        full;
    logic        overrun;
    logic        ovr_clr;
    logic        irq_en;
    logic        irq;

    modport master (
        output rx_data, rx_received, rx_en, rd_strobe, ovr_clr, irq_en,
        input  rd_data, rd_valid, count, empty, full, overrun, irq
    );

    modport slave (
        input  rx_data, rx_received, rx_en, rd_strobe, ovr_clr, irq_en,
        output rd_data, rd_valid, count, empty, full, overrun, irq
    );
endinterface

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO storage with registered count/empty/full.
// Ports: clk, rst (sync, active-low), wr_en/wr_data push, rd_en pop,
//        head = entry at the read pointer, count/count_next fill level,
//        empty, full.
// The caller only asserts wr_en when there is room (or a pop in the same
// cycle) and rd_en when non-empty; no qualification is done here.
module uart_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] head,
    output logic [AW:0]   count,
    output logic [AW:0]   count_next,
    output logic          empty,
    output logic          full
);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign head = mem[rd_ptr];

    always_comb begin
        count_next = count + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, rd_en};
    end

    // Storage needs no reset: pointer reset discards the contents.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + AW'(wr_en);
            rd_ptr <= rd_ptr + AW'(rd_en);
            count  <= count_next;
            empty  <= (count_next == '0);
            full   <= (count_next == FULL_LVL);
        end
    end
endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive-side controller: captures each byte reported by the receiver
// into a FIFO, serves CPU reads with a one-cycle valid pulse, tracks
// overrun and idle timeout, and raises a registered interrupt.
// Ports: clk, rst (sync, active-low), bus (slave modport) carrying
//        rx_data/rx_received/rx_en, rd_strobe/rd_data/rd_valid,
//        count/empty/full, overrun/ovr_clr, irq_en/irq.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DEPTH          = RX_FIFO_DEPTH,
    parameter int AW             = 4,
    parameter int IRQ_THRESH     = 8,
    parameter int TIMEOUT_CYCLES = 17360
) (
    input  logic          clk,
    input  logic          rst,
    uart_rx_ctrl_if.slave bus
);
    localparam logic [14:0] TMO = 15'(TIMEOUT_CYCLES);
    localparam logic [AW:0] THR = (AW+1)'(IRQ_THRESH);

    logic        rx_recv_d;
    logic        push_req;   // new byte offered by the receiver
    logic        wr;         // byte actually stored
    logic        pop;
    logic        ovr_set;
    logic        overrun_next;
    logic [7:0]  head;
    logic [AW:0] count_next;
    logic [14:0] tmo_cnt;
    logic        tmo_hit;
    rx_state_t   state_q, state_next;

    // Rising edge of the byte-done flag; a long level gives one push.
    assign push_req = bus.rx_received & ~rx_recv_d & bus.rx_en;
    assign pop      = bus.rd_strobe & ~bus.empty;
    // When full, a same-cycle pop frees the slot being written.
    assign wr       = push_req & (~bus.full | pop);
    assign ovr_set  = push_req & bus.full & ~pop;
    // Set wins over a simultaneous clear.
    assign overrun_next = ovr_set | (bus.overrun & ~bus.ovr_clr);
    assign tmo_hit  = (tmo_cnt == TMO);

    uart_sync_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (8)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr),
        .wr_data    (bus.rx_data),
        .rd_en      (pop),
        .head       (head),
        .count      (bus.count),
        .count_next (count_next),
        .empty      (bus.empty),
        .full       (bus.full)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_recv_d    <= 1'b0;
            bus.rd_data  <= 8'h00;
            bus.rd_valid <= 1'b0;
            bus.overrun  <= 1'b0;
            bus.irq      <= 1'b0;
            tmo_cnt      <= '0;
        end else begin
            rx_recv_d    <= bus.rx_received;
            bus.rd_valid <= pop;
            if (pop)
                bus.rd_data <= head;
            bus.overrun  <= overrun_next;
            bus.irq      <= bus.irq_en & ((count_next >= THR) | tmo_hit | overrun_next);
            if (push_req || pop || bus.empty)
                tmo_cnt <= '0;
            else if (!tmo_hit)
                tmo_cnt <= tmo_cnt + 15'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_next;
    end

    always_comb begin
        state_next = state_q;
        case (state_q)
            ST_IDLE:      if (wr) state_next = ST_FILLING;
            ST_FILLING:   if (tmo_hit) state_next = ST_TIMED_OUT;
            ST_TIMED_OUT: if (push_req || pop) state_next = ST_FILLING;
            default:      state_next = ST_IDLE;
        endcase
        if (count_next == '0)
            state_next = ST_IDLE;
    end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
module tb_uart_rx_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    uart_rx_ctrl_if #(.AW(4)) bus ();

    uart_rx_ctrl #(
        .DEPTH(16), .AW(4), .IRQ_THRESH(8), .TIMEOUT_CYCLES(17360)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Inputs change 1 time unit after a rising edge; outputs sampled there too.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Byte-done flag high for 'hold' cycles, then 'gap' idle cycles.
    // rx_data carries junk when the flag is low.
    task automatic push(input logic [7:0] b, input int hold, input int gap);
        bus.rx_data     = b;
        bus.rx_received = 1'b1;
        tick(hold);
        bus.rx_received = 1'b0;
        bus.rx_data     = 8'hEE;
        tick(gap);
    endtask

    task automatic rd(input string tag, input logic [7:0] exp);
        bus.rd_strobe = 1'b1;
        tick();
        bus.rd_strobe = 1'b0;
        chk({tag, "_valid"}, 32'(bus.rd_valid), 32'd1);
        chk({tag, "_data"}, 32'(bus.rd_data), 32'(exp));
        tick();
        chk({tag, "_pulse"}, 32'(bus.rd_valid), 32'd0);
    endtask

    initial begin
        rst             = 1'b0;
        bus.rx_data     = 8'hEE;
        bus.rx_received = 1'b0;
        bus.rx_en       = 1'b1;
        bus.rd_strobe   = 1'b0;
        bus.ovr_clr     = 1'b0;
        bus.irq_en      = 1'b0;
        tick(2);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_full", 32'(bus.full), 32'd0);
        chk("rst_ovr", 32'(bus.overrun), 32'd0);
        chk("rst_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst_rdata", 32'(bus.rd_data), 32'd0);
        chk("rst_irq", 32'(bus.irq), 32'd0);
        rst = 1'b1;
        tick();

        // Three bytes, then read them back in order
        push(8'h41, 1, 10);
        push(8'h42, 1, 10);
        push(8'h43, 1, 10);
        chk("t1_count3", 32'(bus.count), 32'd3);
        rd("t1_r0", 8'h41);
        chk("t1_count2", 32'(bus.count), 32'd2);
        rd("t1_r1", 8'h42);
        rd("t1_r2", 8'h43);
        chk("t1_count0", 32'(bus.count), 32'd0);
        chk("t1_empty", 32'(bus.empty), 32'd1);

        // Long flag level gives one entry
        push(8'h55, 5, 3);
        chk("t2_count", 32'(bus.count), 32'd1);
        rd("t2_r", 8'h55);
        chk("t2_empty", 32'(bus.empty), 32'd1);

        // Fill, overflow, drain
        bus.irq_en = 1'b1;
        for (int i = 0; i < 16; i++) push(8'(i), 1, 2);
        chk("t3_full", 32'(bus.full), 32'd1);
        chk("t3_count16", 32'(bus.count), 32'd16);
        chk("t3_ovr0", 32'(bus.overrun), 32'd0);
        chk("t3_irq", 32'(bus.irq), 32'd1);
        push(8'h10, 1, 2);
        chk("t3_ovr1", 32'(bus.overrun), 32'd1);
        chk("t3_count_hold", 32'(bus.count), 32'd16);
        for (int i = 0; i < 16; i++) rd($sformatf("t3_drain%0d", i), 8'(i));
        chk("t3_empty", 32'(bus.empty), 32'd1);
        chk("t3_ovr_sticky", 32'(bus.overrun), 32'd1);
        chk("t3_irq_ovr", 32'(bus.irq), 32'd1);
        // Read while empty: no pulse, data holds
        bus.rd_strobe = 1'b1;
        tick();
        bus.rd_strobe = 1'b0;
        chk("t3_empty_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("t3_empty_rd_data", 32'(bus.rd_data), 32'h0F);
        bus.ovr_clr = 1'b1;
        tick();
        bus.ovr_clr = 1'b0;
        chk("t3_ovr_clr", 32'(bus.overrun), 32'd0);
        chk("t3_irq_clr", 32'(bus.irq), 32'd0);
        bus.irq_en = 1'b0;

        // Push + pop together while full
        for (int i = 0; i < 16; i++) push(8'hA0 + 8'(i), 1, 1);
        chk("t4_full", 32'(bus.full), 32'd1);
        bus.rx_data     = 8'hAA;
        bus.rx_received = 1'b1;
        bus.rd_strobe   = 1'b1;
        tick();
        bus.rx_received = 1'b0;
        bus.rx_data     = 8'hEE;
        bus.rd_strobe   = 1'b0;
        chk("t4_valid", 32'(bus.rd_valid), 32'd1);
        chk("t4_data", 32'(bus.rd_data), 32'hA0);
        chk("t4_ovr", 32'(bus.overrun), 32'd0);
        chk("t4_count", 32'(bus.count), 32'd16);
        tick();
        for (int i = 1; i < 16; i++) rd($sformatf("t4_drain%0d", i), 8'hA0 + 8'(i));
        rd("t4_last", 8'hAA);
        // Push + pop together while empty
        bus.rx_data     = 8'hBB;
        bus.rx_received = 1'b1;
        bus.rd_strobe   = 1'b1;
        tick();
        bus.rx_received = 1'b0;
        bus.rx_data     = 8'hEE;
        bus.rd_strobe   = 1'b0;
        chk("t4e_valid", 32'(bus.rd_valid), 32'd0);
        chk("t4e_count", 32'(bus.count), 32'd1);
        chk("t4e_data_hold", 32'(bus.rd_data), 32'hAA);
        tick();
        rd("t4e_r", 8'hBB);

        // Idle timeout
        bus.irq_en = 1'b1;
        push(8'h77, 1, 0);
        tick(17360);
        chk("t5_irq_before", 32'(bus.irq), 32'd0);
        tick();
        chk("t5_irq_after", 32'(bus.irq), 32'd1);
        rd("t5_r", 8'h77);
        chk("t5_irq_pop", 32'(bus.irq), 32'd0);

        // Reset mid-stream
        for (int i = 0; i < 5; i++) push(8'h60 + 8'(i), 1, 1);
        chk("t6_count5", 32'(bus.count), 32'd5);
        rst           = 1'b0;
        bus.rd_strobe = 1'b1;
        tick();
        rst           = 1'b1;
        bus.rd_strobe = 1'b0;
        chk("t6_count", 32'(bus.count), 32'd0);
        chk("t6_empty", 32'(bus.empty), 32'd1);
        chk("t6_irq", 32'(bus.irq), 32'd0);
        chk("t6_ovr", 32'(bus.overrun), 32'd0);
        chk("t6_valid", 32'(bus.rd_valid), 32'd0);
        bus.rx_en = 1'b0;
        push(8'h12, 1, 2);
        chk("t6_rxen_off", 32'(bus.count), 32'd0);
        bus.rx_en = 1'b1;
        push(8'h34, 1, 2);
        chk("t6_rxen_on", 32'(bus.count), 32'd1);
        rd("t6_r", 8'h34);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
